// File: rtl/debug_cmd_hub.sv
// SPI byte command hub: decodes move/mode/divider/telemetry-select commands,
// generates the game tick in one of four modes and exposes telemetry counters.
module debug_cmd_hub #(
  parameter int NUM_CHANNELS = 4,
  parameter int VALUE_WIDTH  = 8,
  parameter int DIV_WIDTH    = 16,
  parameter int DEFAULT_DIV  = 4096,
  parameter int TIMEOUT      = 1024
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic [7:0]                                 rx_byte,
  input  logic                                       rx_valid,
  output logic                                       rx_clear,
  input  logic                                       ext_step,
  output logic [1:0]                                 move,
  output logic [2:0]                                 piece_sel,
  output logic                                       move_valid,
  output logic                                       game_tick,
  output logic [1:0]                                 clk_mode,
  output logic [NUM_CHANNELS-1:0][VALUE_WIDTH-1:0]   telemetry_values,
  output logic [7:0]                                 tx_byte
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIV_HI = 2'd1,
    ST_DIV_LO = 2'd2
  } state_t;

  state_t                 state_r, state_s;
  logic                   accept_s;
  logic                   move_load_s, mode_load_s, sel_load_s, hi_load_s;
  logic                   div_load_s, div_err_s, timeout_s, cmd_s, tick_s;
  logic [DIV_WIDTH-1:0]   new_div_s, div_cnt_s;
  logic [IDLE_W-1:0]      idle_cnt_s;

  logic                   rx_clear_r, move_valid_r, game_tick_r, ext_prev_r;
  logic [1:0]             move_r, mode_r;
  logic [2:0]             piece_r;
  logic [5:0]             sel_r;
  logic [7:0]             hi_r;
  logic [DIV_WIDTH-1:0]   div_r, div_cnt_r;
  logic [IDLE_W-1:0]      idle_cnt_r;
  logic [VALUE_WIDTH-1:0] tick_cnt_r, last_byte_r, cmd_cnt_r, err_cnt_r;

  function automatic logic [7:0] low_byte(input logic [VALUE_WIDTH-1:0] v);
    logic [VALUE_WIDTH+7:0] wide;
    wide = {8'h00, v};
    return wide[7:0];
  endfunction

  // A byte arriving during the rx_clear cycle is the one just consumed.
  assign accept_s  = rx_valid & ~rx_clear_r;
  assign new_div_s = DIV_WIDTH'({hi_r, rx_byte});

  // Command decode and next-state logic.
  always_comb begin
    state_s     = state_r;
    move_load_s = 1'b0;
    mode_load_s = 1'b0;
    sel_load_s  = 1'b0;
    hi_load_s   = 1'b0;
    div_load_s  = 1'b0;
    div_err_s   = 1'b0;
    timeout_s   = 1'b0;
    cmd_s       = 1'b0;
    idle_cnt_s  = '0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          cmd_s = 1'b1;
          case (rx_byte[7:6])
            2'b00:   move_load_s = 1'b1;
            2'b01:   mode_load_s = 1'b1;
            2'b10:   state_s     = ST_DIV_HI;
            2'b11:   sel_load_s  = 1'b1;
            default: state_s     = ST_IDLE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DIV_HI, ST_DIV_LO: begin
        if (accept_s) begin
          if (state_r == ST_DIV_HI) begin
            hi_load_s = 1'b1;
            state_s   = ST_DIV_LO;
          end else if (new_div_s == '0) begin
            div_err_s = 1'b1;
            state_s   = ST_IDLE;
          end else begin
            div_load_s = 1'b1;
            state_s    = ST_IDLE;
          end
        end else if (idle_cnt_r == IDLE_W'(TIMEOUT - 1)) begin
          timeout_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          idle_cnt_s = idle_cnt_r + IDLE_W'(1);
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Tick decision always uses the mode held before this cycle's update.
  always_comb begin
    case (mode_r)
      2'd0:    tick_s = 1'b0;
      2'd1:    tick_s = ext_step & ~ext_prev_r;
      2'd2:    tick_s = (div_cnt_r == div_r - DIV_WIDTH'(1));
      2'd3:    tick_s = move_valid_r;
      default: tick_s = 1'b0;
    endcase
  end

  // Divider counter runs only in divided mode and restarts on any mode or divider load.
  always_comb begin
    if (mode_load_s | div_load_s) begin
      div_cnt_s = '0;
    end else if ((mode_r == 2'd2) && !tick_s) begin
      div_cnt_s = div_cnt_r + DIV_WIDTH'(1);
    end else begin
      div_cnt_s = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath registers, strobes and telemetry counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_clear_r   <= 1'b0;
      move_valid_r <= 1'b0;
      game_tick_r  <= 1'b0;
      ext_prev_r   <= 1'b0;
      move_r       <= 2'd0;
      piece_r      <= 3'd0;
      mode_r       <= 2'd0;
      sel_r        <= 6'd0;
      hi_r         <= 8'h00;
      div_r        <= DIV_WIDTH'(DEFAULT_DIV);
      div_cnt_r    <= '0;
      idle_cnt_r   <= '0;
      tick_cnt_r   <= '0;
      last_byte_r  <= '0;
      cmd_cnt_r    <= '0;
      err_cnt_r    <= '0;
    end else begin
      rx_clear_r   <= accept_s;
      move_valid_r <= move_load_s & rx_byte[5];
      game_tick_r  <= tick_s;
      ext_prev_r   <= ext_step;
      div_cnt_r    <= div_cnt_s;
      idle_cnt_r   <= idle_cnt_s;
      if (move_load_s) begin
        move_r  <= rx_byte[1:0];
        piece_r <= rx_byte[4:2];
      end
      if (mode_load_s) mode_r <= rx_byte[1:0];
      if (sel_load_s)  sel_r  <= rx_byte[5:0];
      if (hi_load_s)   hi_r   <= rx_byte;
      if (div_load_s)  div_r  <= new_div_s;
      if (accept_s)    last_byte_r <= VALUE_WIDTH'(rx_byte);
      if (tick_s)      tick_cnt_r  <= tick_cnt_r + VALUE_WIDTH'(1);
      if (cmd_s)       cmd_cnt_r   <= cmd_cnt_r + VALUE_WIDTH'(1);
      if (div_err_s | timeout_s) err_cnt_r <= err_cnt_r + VALUE_WIDTH'(1);
    end
  end

  assign rx_clear   = rx_clear_r;
  assign move       = move_r;
  assign piece_sel  = piece_r;
  assign move_valid = move_valid_r;
  assign game_tick  = game_tick_r;
  assign clk_mode   = mode_r;

  // Telemetry map and SPI readback mux; channels 4 and up read zero.
  always_comb begin
    telemetry_values    = '0;
    telemetry_values[0] = tick_cnt_r;
    telemetry_values[1] = last_byte_r;
    telemetry_values[2] = cmd_cnt_r;
    telemetry_values[3] = err_cnt_r;
    case (sel_r)
      6'd0:    tx_byte = low_byte(tick_cnt_r);
      6'd1:    tx_byte = low_byte(last_byte_r);
      6'd2:    tx_byte = low_byte(cmd_cnt_r);
      6'd3:    tx_byte = low_byte(err_cnt_r);
      default: tx_byte = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_debug_cmd_hub.sv
// Randomized and directed bench for debug_cmd_hub, checked every cycle against
// a behavioural model of the command/tick/telemetry rules.
module tb_debug_cmd_hub;

  localparam int TIMEOUT = 1024;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [7:0]      rx_byte;
  logic            rx_valid;
  logic            rx_clear;
  logic            ext_step;
  logic [1:0]      move;
  logic [2:0]      piece_sel;
  logic            move_valid;
  logic            game_tick;
  logic [1:0]      clk_mode;
  logic [3:0][7:0] telemetry_values;
  logic [7:0]      tx_byte;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_seen = 0;

  int m_pend, m_hi, m_idle, m_mode, m_div, m_cnt, m_move, m_piece, m_sel;
  int m_ticks, m_last, m_cmds, m_errs;
  bit m_rxc, m_mv, m_gt, m_prev;

  debug_cmd_hub #(
    .NUM_CHANNELS(4), .VALUE_WIDTH(8), .DIV_WIDTH(16),
    .DEFAULT_DIV(4096), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .rx_clear(rx_clear), .ext_step(ext_step), .move(move), .piece_sel(piece_sel),
    .move_valid(move_valid), .game_tick(game_tick), .clk_mode(clk_mode),
    .telemetry_values(telemetry_values), .tx_byte(tx_byte)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_hi = 0; m_idle = 0; m_mode = 0; m_div = 4096; m_cnt = 0;
    m_move = 0; m_piece = 0; m_sel = 0; m_ticks = 0; m_last = 0; m_cmds = 0;
    m_errs = 0; m_rxc = 0; m_mv = 0; m_gt = 0; m_prev = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs the DUT sampled.
  task automatic model_update();
    int b, nd, old_mode;
    bit acc, tk, n_mv, clr;
    if (!reset_n) begin
      model_reset();
      return;
    end
    b   = int'(rx_byte);
    acc = rx_valid && !m_rxc;
    case (m_mode)
      1:       tk = ext_step && !m_prev;
      2:       tk = (m_cnt == m_div - 1);
      3:       tk = m_mv;
      default: tk = 1'b0;
    endcase
    n_mv = 1'b0; clr = 1'b0; old_mode = m_mode;
    if (m_pend == 0) begin
      if (acc) begin
        m_cmds = (m_cmds + 1) % 256;
        case (b / 64)
          0:       begin m_move = b % 4; m_piece = (b / 4) % 8; n_mv = bit'((b / 32) % 2); end
          1:       begin m_mode = b % 4; clr = 1'b1; end
          2:       begin m_pend = 2; m_idle = 0; end
          default: m_sel = b % 64;
        endcase
      end
    end else if (acc) begin
      m_idle = 0;
      if (m_pend == 2) begin
        m_hi = b; m_pend = 1;
      end else begin
        nd = m_hi * 256 + b; m_pend = 0;
        if (nd == 0) m_errs = (m_errs + 1) % 256;
        else begin m_div = nd; clr = 1'b1; end
      end
    end else begin
      m_idle++;
      if (m_idle == TIMEOUT) begin m_pend = 0; m_errs = (m_errs + 1) % 256; end
    end
    if (clr) m_cnt = 0;
    else if (old_mode == 2) m_cnt = tk ? 0 : m_cnt + 1;
    else m_cnt = 0;
    if (tk) m_ticks = (m_ticks + 1) % 256;
    if (acc) m_last = b;
    m_gt = tk; m_rxc = acc; m_mv = n_mv; m_prev = ext_step;
  endtask

  function automatic int m_tx();
    case (m_sel)
      0:       return m_ticks;
      1:       return m_last;
      2:       return m_cmds;
      3:       return m_errs;
      default: return 0;
    endcase
  endfunction

  task automatic compare_all();
    check_eq("rx_clear",   rx_clear,   m_rxc);
    check_eq("move_valid", move_valid, m_mv);
    check_eq("move",       move,       m_move);
    check_eq("piece_sel",  piece_sel,  m_piece);
    check_eq("game_tick",  game_tick,  m_gt);
    check_eq("clk_mode",   clk_mode,   m_mode);
    check_eq("tel_ticks",  telemetry_values[0], m_ticks);
    check_eq("tel_last",   telemetry_values[1], m_last);
    check_eq("tel_cmds",   telemetry_values[2], m_cmds);
    check_eq("tel_errs",   telemetry_values[3], m_errs);
    check_eq("tx_byte",    tx_byte,    m_tx());
  endtask

  task automatic tick_cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
    if (game_tick === 1'b1) tick_seen++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_byte = b;
    tick_cycle();
    rx_valid = 1'b0;
    tick_cycle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (2) tick_cycle();
    reset_n = 1'b1;
    tick_seen = 0;
  endtask

  task automatic run_count(input int n, output int c);
    int base;
    base = tick_seen;
    repeat (n) tick_cycle();
    c = tick_seen - base;
  endtask

  initial begin
    int c, pulses, last_cyc, start_ticks;
    reset_n = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; ext_step = 1'b0;
    model_reset();
    repeat (2) tick_cycle();
    reset_n = 1'b1;

    // Single MOVE command with strobe.
    rx_valid = 1'b1; rx_byte = 8'h2D;
    tick_cycle();
    check_eq("req029_rx_clear", rx_clear, 32'd1);
    check_eq("req029_move", move, 32'd1);
    check_eq("req029_piece", piece_sel, 32'd3);
    check_eq("req029_strobe", move_valid, 32'd1);
    check_eq("req029_cmds", telemetry_values[2], 32'd1);
    rx_valid = 1'b0;
    tick_cycle();
    check_eq("req029_strobe_once", move_valid, 32'd0);

    // Divided mode with divider 5.
    send_byte(8'h42); send_byte(8'h80); send_byte(8'h00); send_byte(8'h05);
    pulses = 0; last_cyc = -1; start_ticks = m_ticks;
    for (int i = 0; i < 60 && pulses < 4; i++) begin
      tick_cycle();
      if (game_tick === 1'b1) begin
        pulses++;
        if (last_cyc >= 0) check_eq("req030_period", i - last_cyc, 32'd5);
        check_eq("req030_tick_cnt", telemetry_values[0], (start_ticks + pulses) % 256);
        last_cyc = i;
      end
    end
    check_eq("req030_pulses", pulses, 32'd4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_byte  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) ext_step = ~ext_step;
      tick_cycle();
    end
    rx_valid = 1'b0; ext_step = 1'b0;
    tick_cycle();

    // Timeout between divider bytes; divider must remain the reset default.
    do_reset();
    send_byte(8'h80); send_byte(8'h00);
    repeat (1030) tick_cycle();
    check_eq("req031_errs", telemetry_values[3], 32'd1);
    send_byte(8'h42);
    run_count(4094, c);
    check_eq("req031_no_early_tick", c, 32'd0);
    run_count(1, c);
    check_eq("req031_tick_at_4096", c, 32'd1);

    // Held external step gives one tick.
    do_reset();
    send_byte(8'h41);
    ext_step = 1'b1;
    run_count(50, c);
    check_eq("req032_one_tick", c, 32'd1);
    ext_step = 1'b0;
    tick_cycle();

    // Tick counter wrap and out-of-range telemetry select.
    do_reset();
    send_byte(8'h80); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h42);
    for (int i = 0; i < 400 && tick_seen < 256; i++) tick_cycle();
    check_eq("req033_ticks_seen", tick_seen, 32'd256);
    check_eq("req033_wrap", telemetry_values[0], 32'd0);
    send_byte(8'h40);
    send_byte(8'hC7);
    check_eq("req033_tx_zero", tx_byte, 32'd0);

    // Reset between divider bytes aborts the load.
    do_reset();
    send_byte(8'h80); send_byte(8'h00);
    do_reset();
    check_eq("req034_mode", clk_mode, 32'd0);
    check_eq("req034_errs", telemetry_values[3], 32'd0);
    check_eq("req034_cmds", telemetry_values[2], 32'd0);
    send_byte(8'h42);
    run_count(4094, c);
    check_eq("req034_no_early_tick", c, 32'd0);
    run_count(1, c);
    check_eq("req034_tick_at_4096", c, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
